// File: rtl/prn_epl_taps.sv
// prn_epl_taps
// Builds early / prompt / late code replicas from the single-bit PRN stream
// of prn_ram. Each 1/8-chip step of the channel code phase (a change in
// phase_hi) shifts {code_in, mask_in} into a sample history. The history is
// tapped at positions 0, S and 2S, where S is the active E-P spacing.
//
// Parameters
//   DEPTH        history length in 1/8-chip samples (>= 15)
// Ports
//   clk          channel processing clock (pclk domain)
//   rst          asynchronous, active-high reset
//   code_in      PRN bit from prn_ram.code_out
//   mask_in      mask bit from prn_ram.mask
//   phase_hi     top 3 bits of the code phase from time_scale_ch
//   epoch_pulse  one-cycle epoch strobe; the only point where spacing loads
//   spacing      requested E-P (= P-L) spacing in 1/8 chip (0 means 1)
//   early        early replica bit   (hist[0])
//   prompt       prompt replica bit  (hist[S])
//   late         late replica bit    (hist[2S])
//   mask_p       mask bit aligned to prompt
//   epl_valid    all three taps hold real samples
//   el_diff      signed E-L discriminator input, value(early)-value(late)
//
// Build option
//   PRN_EPL_DIFF_EN  when defined, el_diff is computed (bit 0 -> +1,
//                    bit 1 -> -1) and forced to 0 while epl_valid is low.
//                    When undefined, el_diff is tied to 0.
module prn_epl_taps #(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_in,
  input  logic              mask_in,
  input  logic [2:0]        phase_hi,
  input  logic              epoch_pulse,
  input  logic [2:0]        spacing,
  output logic              early,
  output logic              prompt,
  output logic              late,
  output logic              mask_p,
  output logic              epl_valid,
  output logic signed [2:0] el_diff
);

  localparam int IW = $clog2(DEPTH);

  logic [2:0]       phase_hi_q;
  logic             tick;
  logic [DEPTH-1:0] code_hist, code_hist_n;
  logic [DEPTH-1:0] mask_hist, mask_hist_n;
  logic [2:0]       spc_s, spc_n;
  logic [4:0]       fill, fill_n;
  logic [4:0]       two_s_n;
  logic [IW-1:0]    idx_p, idx_l;
  logic             valid_n;

  // Outputs are registered from the next-state history and spacing, so a
  // tick or a spacing change is visible one clock after the cycle it occurs.
  always_comb begin
    tick        = (phase_hi != phase_hi_q);
    code_hist_n = code_hist;
    mask_hist_n = mask_hist;
    if (tick) begin
      code_hist_n = {code_hist[DEPTH-2:0], code_in};
      mask_hist_n = {mask_hist[DEPTH-2:0], mask_in};
    end

    spc_n = spc_s;
    if (epoch_pulse)
      spc_n = (spacing == 3'd0) ? 3'd1 : spacing;
    two_s_n = {1'b0, spc_n, 1'b0};

    // A real spacing change restarts the fill count and swallows a
    // coincident tick; reloading the same spacing leaves the count alone.
    fill_n = fill;
    if (spc_n != spc_s)
      fill_n = 5'd0;
    else if (tick && (fill < two_s_n))
      fill_n = 5'(fill + 5'd1);

    idx_p   = IW'(spc_n);
    idx_l   = IW'({spc_n, 1'b0});
    valid_n = (fill_n == two_s_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_hi_q <= 3'd0;
      code_hist  <= '0;
      mask_hist  <= '0;
      spc_s      <= 3'd1;
      fill       <= 5'd0;
      early      <= 1'b0;
      prompt     <= 1'b0;
      late       <= 1'b0;
      mask_p     <= 1'b0;
      epl_valid  <= 1'b0;
    end else begin
      phase_hi_q <= phase_hi;
      code_hist  <= code_hist_n;
      mask_hist  <= mask_hist_n;
      spc_s      <= spc_n;
      fill       <= fill_n;
      early      <= code_hist_n[0];
      prompt     <= code_hist_n[idx_p];
      late       <= code_hist_n[idx_l];
      mask_p     <= mask_hist_n[idx_p];
      epl_valid  <= valid_n;
    end
  end

`ifdef PRN_EPL_DIFF_EN
  // Equal taps give 0; early=0/late=1 is +1-(-1) = +2; the reverse is -2.
  function automatic logic signed [2:0] epl_diff(input logic e, input logic l,
                                                 input logic v);
    if (!v || (e == l))
      return 3'sd0;
    else if (e)
      return -3'sd2;
    else
      return 3'sd2;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      el_diff <= 3'sd0;
    else
      el_diff <= epl_diff(code_hist_n[0], code_hist_n[idx_l], valid_n);
  end
`else
  assign el_diff = 3'sd0;
`endif

endmodule

// File: tb/tb_prn_epl_taps.sv
module tb_prn_epl_taps;

  logic              clk = 1'b0;
  logic              rst;
  logic              code_in;
  logic              mask_in;
  logic [2:0]        phase_hi;
  logic              epoch_pulse;
  logic [2:0]        spacing;
  logic              early;
  logic              prompt;
  logic              late;
  logic              mask_p;
  logic              epl_valid;
  logic signed [2:0] el_diff;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference history (bit 0 newest) and the spacing the bench expects.
  logic [15:0] mc;
  logic [15:0] mm;
  int          cur_s;

  always #5 clk = ~clk;

  prn_epl_taps #(.DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .code_in     (code_in),
    .mask_in     (mask_in),
    .phase_hi    (phase_hi),
    .epoch_pulse (epoch_pulse),
    .spacing     (spacing),
    .early       (early),
    .prompt      (prompt),
    .late        (late),
    .mask_p      (mask_p),
    .epl_valid   (epl_valid),
    .el_diff     (el_diff)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_diff(input logic e, input logic l, input logic v);
`ifdef PRN_EPL_DIFF_EN
    if (!v || e == l) return 0;
    return e ? -2 : 2;
`else
    return 0;
`endif
  endfunction

  task automatic check_taps(input string tag, input logic exp_v);
    int el_got;
    el_got = el_diff;
    check_eq({tag, ".early"},  int'(early),     int'(mc[0]));
    check_eq({tag, ".prompt"}, int'(prompt),    int'(mc[cur_s]));
    check_eq({tag, ".late"},   int'(late),      int'(mc[2*cur_s]));
    check_eq({tag, ".mask_p"}, int'(mask_p),    int'(mm[cur_s]));
    check_eq({tag, ".valid"},  int'(epl_valid), int'(exp_v));
    check_eq({tag, ".el_diff"}, el_got, exp_diff(mc[0], mc[2*cur_s], exp_v));
  endtask

  // Step phase_hi by 'jump' with the given sample, check after the update,
  // then idle with the input bits flipped to show nothing shifts between ticks.
  task automatic do_tick(input string tag, input logic c, input logic m,
                         input logic exp_v, input int jump);
    code_in  = c;
    mask_in  = m;
    phase_hi = 3'(phase_hi + 3'(jump));
    @(posedge clk); #1;
    mc = {mc[14:0], c};
    mm = {mm[14:0], m};
    check_taps(tag, exp_v);
    code_in = ~c;
    mask_in = ~m;
    repeat (9) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_epoch(input logic [2:0] spc);
    spacing     = spc;
    epoch_pulse = 1'b1;
    @(posedge clk); #1;
    epoch_pulse = 1'b0;
    cur_s       = (spc == 3'd0) ? 1 : int'(spc);
  endtask

  initial begin
    logic [7:0] pat;
    logic       c;
    pat         = 8'b01011001;  // code pattern 1,0,0,1,1,0,1,0 from bit 0
    rst         = 1'b1;
    code_in     = 1'b0;
    mask_in     = 1'b0;
    phase_hi    = 3'd0;
    epoch_pulse = 1'b0;
    spacing     = 3'd1;
    mc          = '0;
    mm          = '0;
    cur_s       = 1;

    repeat (3) @(posedge clk);
    #1;
    check_taps("reset", 1'b0);
    rst = 1'b0;

    // Spacing 2, then eight ticks; valid on the 4th.
    do_epoch(3'd2);
    check_taps("s2_epoch", 1'b0);
    for (int i = 0; i < 8; i++) begin
      c = pat[i];
      do_tick($sformatf("s2_t%0d", i + 1), c, c ^ logic'(i[0]), logic'(i >= 3), 1);
    end

    // Spacing 0 behaves as 1: valid after two ticks.
    do_epoch(3'd0);
    check_taps("s0_epoch", 1'b0);
    do_tick("s0_t1", 1'b1, 1'b0, 1'b0, 1);
    do_tick("s0_t2", 1'b0, 1'b1, 1'b1, 1);
    do_tick("s0_t3", 1'b1, 1'b1, 1'b1, 1);

    // Spacing 3 until valid, then change to 5.
    do_epoch(3'd3);
    check_taps("s3_epoch", 1'b0);
    for (int i = 0; i < 6; i++)
      do_tick($sformatf("s3_t%0d", i + 1), logic'(i[1]), logic'(i[0]), logic'(i >= 5), 1);
    do_epoch(3'd5);
    check_taps("s5_epoch", 1'b0);
    for (int i = 0; i < 10; i++)
      do_tick($sformatf("s5_t%0d", i + 1), logic'(i[0] ^ i[2]), logic'(i[1]),
              logic'(i >= 9), 1);

    // Epoch coincident with a tick: shift happens, the tick is not counted.
    spacing     = 3'd2;
    epoch_pulse = 1'b1;
    code_in     = 1'b1;
    mask_in     = 1'b0;
    phase_hi    = 3'(phase_hi + 3'd1);
    @(posedge clk); #1;
    epoch_pulse = 1'b0;
    cur_s       = 2;
    mc          = {mc[14:0], 1'b1};
    mm          = {mm[14:0], 1'b0};
    check_taps("coin", 1'b0);
    for (int i = 0; i < 4; i++)
      do_tick($sformatf("coin_t%0d", i + 1), logic'(~i[0]), logic'(i[1]), logic'(i >= 3), 1);

    // Phase jump 2 -> 5 is a single shift; then a long hold.
    do_tick("jump_to2", 1'b0, 1'b1, 1'b1, 2);
    check_eq("jump.phase_start", int'(phase_hi), 2);
    do_tick("jump_2to5", 1'b1, 1'b0, 1'b1, 3);
    repeat (50) begin
      @(posedge clk); #1;
      code_in = ~code_in;
    end
    check_taps("hold50", 1'b1);

    // Early=0 / late=1 and early=1 / late=0 cases for the discriminator.
    do_tick("diff_a", 1'b0, 1'b0, 1'b1, 1);
    do_tick("diff_b", 1'b0, 1'b0, 1'b1, 1);
    do_tick("diff_c", 1'b1, 1'b0, 1'b1, 1);
    do_tick("diff_d", 1'b1, 1'b0, 1'b1, 1);

    // Mid-run reset clears the outputs immediately.
    rst = 1'b1;
    #1;
    mc    = '0;
    mm    = '0;
    cur_s = 1;
    check_taps("midrst", 1'b0);
    phase_hi = 3'd3;
    code_in  = 1'b1;
    mask_in  = 1'b1;
    @(posedge clk); #1;
    check_taps("midrst_hold", 1'b0);
    rst = 1'b0;
    // First tick after release is against phase_hi_q = 0.
    @(posedge clk); #1;
    mc = {mc[14:0], 1'b1};
    mm = {mm[14:0], 1'b1};
    check_taps("post_rst_t1", 1'b0);
    do_tick("post_rst_t2", 1'b0, 1'b0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
